hack_cpu_ctrl: RTL and testbench

Hack-style instruction-execution controller: the initiator side of the 16-bit ALU control interface. Holds the A, D and PC registers and decodes each 16-bit instruction. Drives the ALU operands and its six control bits (zx, nx, zy, ny, f, no), consumes the ALU result and flags (out, zr, ng) for writeback and jump decisions, and issues data-memory accesses with a ready stall.

---
 rtl/hack_isa_pkg.sv | 32 +++
 rtl/hack_cpu_ctrl_if.sv | 38 +++
 rtl/hack_jump_unit.sv | 25 ++
 rtl/hack_cpu_ctrl.sv | 83 ++++++++
 tb/tb_hack_cpu_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/hack_isa_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : hack_isa_pkg                                           |
// | Brief   : Hack ISA widths, instruction field positions, jumps    |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package hack_isa_pkg;

    localparam int W     = 16;
    localparam int AW    = 15;

    localparam int IS_C  = 15;
    localparam int A_BIT = 12;
    localparam int C_MSB = 11;
    localparam int C_LSB = 6;
    localparam int D1    = 5;
    localparam int D2    = 4;
    localparam int D3    = 3;
    localparam int J1    = 2;
    localparam int J2    = 1;
    localparam int J3    = 0;

    localparam logic [2:0] JGT = 3'b001;
    localparam logic [2:0] JEQ = 3'b010;
    localparam logic [2:0] JGE = 3'b011;
    localparam logic [2:0] JLT = 3'b100;
    localparam logic [2:0] JNE = 3'b101;
    localparam logic [2:0] JLE = 3'b110;
    localparam logic [2:0] JMP = 3'b111;

endpackage
`default_nettype wire

// File: rtl/hack_cpu_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : hack_cpu_ctrl_if                                       |
// | Brief   : ALU control and data-memory bus of the Hack controller |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
interface hack_cpu_ctrl_if;
    import hack_isa_pkg::*;

    logic [W-1:0]  alu_x;
    logic [W-1:0]  alu_y;
    logic          zx;
    logic          nx;
    logic          zy;
    logic          ny;
    logic          f;
    logic          no;
    logic [W-1:0]  alu_out;
    logic          alu_zr;
    logic          alu_ng;
    logic [W-1:0]  in_m;
    logic          mem_ready;
    logic [W-1:0]  out_m;
    logic          write_m;
    logic [AW-1:0] address_m;

    modport master (
        output alu_x, alu_y, zx, nx, zy, ny, f, no, out_m, write_m, address_m,
        input  alu_out, alu_zr, alu_ng, in_m, mem_ready
    );

    modport slave (
        input  alu_x, alu_y, zx, nx, zy, ny, f, no, out_m, write_m, address_m,
        output alu_out, alu_zr, alu_ng, in_m, mem_ready
    );

endinterface
`default_nettype wire

// File: rtl/hack_jump_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : hack_jump_unit                                         |
// | Brief   : Combinational jump decision from j-bits and ALU flags  |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module hack_jump_unit
    import hack_isa_pkg::*;
(
    input  wire logic [2:0] jbits,
    input  wire logic       zr,
    input  wire logic       ng,
    input  wire logic       is_c,
    output logic            take
);

    // "Greater than" is neither zero nor negative.
    always_comb begin
        take = is_c & ((jbits[J1] & ng) |
                       (jbits[J2] & zr) |
                       (jbits[J3] & ~zr & ~ng));
    end

endmodule
`default_nettype wire

// File: rtl/hack_cpu_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : hack_cpu_ctrl                                          |
// | Brief   : Hack A/D/PC registers, decode, ALU drive, mem stall    |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module hack_cpu_ctrl
    import hack_isa_pkg::*;
(
    input  wire logic           clk,
    input  wire logic           reset,
    input  wire logic [W-1:0]   instruction,
    output logic [AW-1:0]       pc,
    hack_cpu_ctrl_if.master     bus
);

    logic [W-1:0]  r_a;
    logic [W-1:0]  r_d;
    logic [AW-1:0] r_pc;

    logic          w_is_c;
    logic          w_a;
    logic          w_d1;
    logic          w_d2;
    logic          w_d3;
    logic [5:0]    w_ctrl;
    logic          w_uses_m;
    logic          w_stall;
    logic          w_take;
    logic          w_unused_bits;

    assign w_is_c        = instruction[IS_C];
    assign w_a           = w_is_c & instruction[A_BIT];
    assign w_d1          = w_is_c & instruction[D1];
    assign w_d2          = w_is_c & instruction[D2];
    assign w_d3          = w_is_c & instruction[D3];
    assign w_ctrl        = w_is_c ? instruction[C_MSB:C_LSB] : 6'b000000;
    assign w_unused_bits = ^instruction[14:13];

    // Any access to M waits for the memory; the instruction is held by the fetcher.
    assign w_uses_m = w_is_c & (w_a | w_d3);
    assign w_stall  = w_uses_m & ~bus.mem_ready;

    assign bus.alu_x     = r_d;
    assign bus.alu_y     = w_a ? bus.in_m : r_a;
    assign bus.zx        = w_ctrl[5];
    assign bus.nx        = w_ctrl[4];
    assign bus.zy        = w_ctrl[3];
    assign bus.ny        = w_ctrl[2];
    assign bus.f         = w_ctrl[1];
    assign bus.no        = w_ctrl[0];
    assign bus.out_m     = bus.alu_out;
    assign bus.write_m   = w_d3 & ~reset;
    assign bus.address_m = r_a[AW-1:0];
    assign pc            = r_pc;

    hack_jump_unit u_jump (
        .jbits (instruction[J1:J3]),
        .zr    (bus.alu_zr),
        .ng    (bus.alu_ng),
        .is_c  (w_is_c),
        .take  (w_take)
    );

    // Jump target is the pre-edge A even when the same instruction rewrites A.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a  <= '0;
            r_d  <= '0;
            r_pc <= '0;
        end else if (!w_stall) begin
            if (!w_is_c) begin
                r_a <= instruction;
            end else begin
                if (w_d1) r_a <= bus.alu_out;
                if (w_d2) r_d <= bus.alu_out;
            end
            r_pc <= w_take ? r_a[AW-1:0] : r_pc + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hack_cpu_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_hack_cpu_ctrl                                       |
// | Brief   : Directed self-checking bench for hack_cpu_ctrl         |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_hack_cpu_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] instruction;
    logic [14:0] pc;
    int          vectors;
    int          miscompares;

    hack_cpu_ctrl_if bus ();

    hack_cpu_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .pc          (pc),
        .bus         (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] ctrl();
        return {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        instruction   = 16'h0000;
        bus.in_m      = 16'h0000;
        bus.mem_ready = 1'b1;
        bus.alu_out   = 16'h0000;
        bus.alu_zr    = 1'b0;
        bus.alu_ng    = 1'b0;

        // Reset
        tick;
        tick;
        chk("reset_pc",      32'(pc), 32'h0);
        chk("reset_addr",    32'(bus.address_m), 32'h0);
        chk("reset_d",       32'(bus.alu_x), 32'h0);
        chk("reset_write_m", 32'(bus.write_m), 32'h0);

        // @5
        reset       = 1'b0;
        instruction = 16'h0005;
        #1;
        chk("ainstr_ctrl",    32'(ctrl()), 32'h0);
        chk("ainstr_write_m", 32'(bus.write_m), 32'h0);
        tick;
        chk("ainstr_pc",   32'(pc), 32'h1);
        chk("ainstr_addr", 32'(bus.address_m), 32'h5);

        // D=A
        instruction = 16'hEC10;
        bus.alu_out = 16'h0005;
        #1;
        chk("d_eq_a_ctrl", 32'(ctrl()), 32'h30);
        chk("d_eq_a_y",    32'(bus.alu_y), 32'h5);
        tick;
        chk("d_eq_a_pc", 32'(pc), 32'h2);
        chk("d_eq_a_d",  32'(bus.alu_x), 32'h5);

        // D=D+A
        instruction = 16'hE090;
        bus.alu_out = 16'h000A;
        #1;
        chk("dplusa_ctrl", 32'(ctrl()), 32'h02);
        chk("dplusa_x",    32'(bus.alu_x), 32'h5);
        chk("dplusa_y",    32'(bus.alu_y), 32'h5);
        tick;
        chk("dplusa_d",  32'(bus.alu_x), 32'hA);
        chk("dplusa_pc", 32'(pc), 32'h3);

        // @100 then M=D with three stalled cycles
        instruction = 16'h0064;
        tick;
        chk("a100_pc", 32'(pc), 32'h4);
        instruction   = 16'hE308;
        bus.alu_out   = 16'h000A;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_write_m", 32'(bus.write_m), 32'h1);
            chk("stall_addr",    32'(bus.address_m), 32'd100);
            chk("stall_out_m",   32'(bus.out_m), 32'hA);
            tick;
            chk("stall_pc", 32'(pc), 32'h4);
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("commit_write_m", 32'(bus.write_m), 32'h1);
        tick;
        chk("commit_pc",   32'(pc), 32'h5);
        chk("commit_addr", 32'(bus.address_m), 32'd100);

        // @42; D;JGT negative -> fall through, positive -> jump
        instruction = 16'h002A;
        tick;
        chk("a42_pc", 32'(pc), 32'h6);
        instruction = 16'hE301;
        bus.alu_out = 16'hFFFF;
        bus.alu_ng  = 1'b1;
        bus.alu_zr  = 1'b0;
        tick;
        chk("jgt_neg_pc", 32'(pc), 32'h7);
        bus.alu_out = 16'h0003;
        bus.alu_ng  = 1'b0;
        tick;
        chk("jgt_pos_pc", 32'(pc), 32'd42);

        // 0;JMP from pc 42 with zero flag set
        instruction = 16'hEA87;
        bus.alu_out = 16'h0000;
        bus.alu_zr  = 1'b1;
        #1;
        chk("jmp_ctrl", 32'(ctrl()), 32'h2A);
        tick;
        chk("jmp_pc", 32'(pc), 32'd42);

        // @7; AM=M+1;JMP
        instruction = 16'h0007;
        tick;
        chk("a7_pc", 32'(pc), 32'd43);
        instruction = 16'hFDEF;
        bus.in_m    = 16'h0009;
        bus.alu_out = 16'h000A;
        bus.alu_zr  = 1'b0;
        bus.alu_ng  = 1'b0;
        #1;
        chk("amjmp_y",       32'(bus.alu_y), 32'h9);
        chk("amjmp_ctrl",    32'(ctrl()), 32'h37);
        chk("amjmp_write_m", 32'(bus.write_m), 32'h1);
        chk("amjmp_addr",    32'(bus.address_m), 32'h7);
        chk("amjmp_out_m",   32'(bus.out_m), 32'hA);
        tick;
        chk("amjmp_pc",   32'(pc), 32'h7);
        chk("amjmp_newa", 32'(bus.address_m), 32'hA);
        chk("amjmp_d",    32'(bus.alu_x), 32'hA);

        // pc wrap at 0x7FFF
        instruction = 16'h7FFF;
        tick;
        chk("a7fff_pc", 32'(pc), 32'h8);
        instruction = 16'hEA87;
        bus.alu_out = 16'h0000;
        bus.alu_zr  = 1'b1;
        tick;
        chk("jmp_top_pc", 32'(pc), 32'h7FFF);
        instruction = 16'h0003;
        tick;
        chk("wrap_pc",   32'(pc), 32'h0);
        chk("wrap_addr", 32'(bus.address_m), 32'h3);
        tick;
        chk("post_wrap_pc", 32'(pc), 32'h1);

        // Reset arriving mid-stall
        instruction   = 16'hE308;
        bus.alu_zr    = 1'b0;
        bus.mem_ready = 1'b0;
        tick;
        chk("pre_reset_stall_pc", 32'(pc), 32'h1);
        chk("pre_reset_write_m",  32'(bus.write_m), 32'h1);
        reset = 1'b1;
        #1;
        chk("reset_hi_write_m", 32'(bus.write_m), 32'h0);
        tick;
        chk("midstall_reset_pc",   32'(pc), 32'h0);
        chk("midstall_reset_addr", 32'(bus.address_m), 32'h0);
        chk("midstall_reset_d",    32'(bus.alu_x), 32'h0);
        chk("midstall_write_m",    32'(bus.write_m), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
